// File: rtl/fp_pkg.sv
// fp_pkg: shared types and constants for the programmable beeper divider.
//   fp_state_e : counter FSM states (FP_IDLE, FP_RUN)
//   FP_MIN_DIV : smallest divisor ever stored; smaller requests are clamped up to it
//   FP_CNT_W   : default counter/divisor/duty width
package fp_pkg;
   typedef enum logic {FP_IDLE, FP_RUN} fp_state_e;
   localparam int FP_MIN_DIV = 2;
   localparam int FP_CNT_W   = 16;
endpackage

// File: rtl/fp_cfg_shadow.sv
// fp_cfg_shadow: config shadow registers for fp_prog_div.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_valid/cfg_ready valid/ready config handshake (ready is low while a config is pending)
//   cfg_div, cfg_duty   requested period and low-phase length
//   apply               strobe from the counter FSM; moves the shadow into the live settings
//   pending             a captured config waits for apply
//   div                 live divisor
//   nxt_duty            duty that is live after the current edge
// Macro FP_DUTY_EN: when defined cfg_duty is captured; otherwise duty = div >> 1.
module fp_cfg_shadow
   import fp_pkg::*;
#(
   parameter int CNT_W    = FP_CNT_W,
   parameter int DEF_DIV  = 50,
   parameter int DEF_DUTY = 25
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_duty,
   input  logic             apply,
   output logic             pending,
   output logic [CNT_W-1:0] div,
   output logic [CNT_W-1:0] nxt_duty
);
   localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(FP_MIN_DIV);
   localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);
   logic [CNT_W-1:0] sh_div, sh_duty, duty, cd, cduty;
   assign cd = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
`ifdef FP_DUTY_EN
   localparam logic [CNT_W-1:0] RST_DUTY = CNT_W'(DEF_DUTY);
   assign cduty = cfg_duty;
`else
   // duty tracks the (clamped) divisor so the wave stays ~50%
   localparam logic [CNT_W-1:0] RST_DUTY = RST_DIV >> 1;
   logic unused_duty;
   assign unused_duty = ^{cfg_duty, CNT_W'(DEF_DUTY)};
   assign cduty = cd >> 1;
`endif
   assign nxt_duty = apply ? sh_duty : duty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_div    <= RST_DIV;
         sh_duty   <= RST_DUTY;
         div       <= RST_DIV;
         duty      <= RST_DUTY;
         pending   <= 1'b0;
         cfg_ready <= 1'b1;
      end else begin
         div  <= apply ? sh_div : div;
         duty <= nxt_duty;
         if (cfg_valid && cfg_ready) begin
            sh_div    <= cd;
            sh_duty   <= cduty;
            pending   <= 1'b1;
            cfg_ready <= 1'b0;
         end else if (apply) begin
            pending   <= 1'b0;
            cfg_ready <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/fp_prog_div.sv
// fp_prog_div: runtime-programmable square-wave divider driving the active-low beeper gate.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  run enable (level)
//   cfg_valid/cfg_ready config handshake
//   cfg_div, cfg_duty   requested period / low-phase cycles
//   fm                  beeper gate, low = active
//   period_tick         one-cycle pulse when cnt == 0
//   active              high while in RUN
// Macro FP_DUTY_EN: programmable duty; without it duty = div >> 1.
module fp_prog_div
   import fp_pkg::*;
#(
   parameter int   CNT_W    = FP_CNT_W,
   parameter int   DEF_DIV  = 50,
   parameter int   DEF_DUTY = 25,
   parameter logic IDLE_LVL = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_duty,
   output logic             fm,
   output logic             period_tick,
   output logic             active
);
   fp_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt, cnt_d, div, nxt_duty;
   logic             pending, apply, wrap, fm_d, tick_d;

   fp_cfg_shadow #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV), .DEF_DUTY(DEF_DUTY)) u_shadow (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_div   (cfg_div),
      .cfg_duty  (cfg_duty),
      .apply     (apply),
      .pending   (pending),
      .div       (div),
      .nxt_duty  (nxt_duty)
   );

   // settings change only at a period boundary in RUN, immediately in IDLE
   assign wrap  = cnt == div - CNT_W'(1);
   assign apply = pending && (state_q == FP_IDLE || wrap);

   always_comb begin
      state_d = en ? FP_RUN : FP_IDLE;
      cnt_d   = (state_q == FP_RUN && en && !wrap) ? cnt + CNT_W'(1) : '0;
      // fm is computed from the count being loaded so it lines up with cnt
      fm_d    = en ? (cnt_d >= nxt_duty) : IDLE_LVL;
      tick_d  = en && cnt_d == '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FP_IDLE;
         cnt         <= '0;
         fm          <= IDLE_LVL;
         period_tick <= 1'b0;
         active      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt         <= cnt_d;
         fm          <= fm_d;
         period_tick <= tick_d;
         active      <= state_d == FP_RUN;
      end
   end
endmodule

// File: tb/tb_fp_prog_div.sv
// tb_fp_prog_div: directed self-checking bench for fp_prog_div.
module tb_fp_prog_div;
   logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, cfg_valid = 1'b0;
   logic [15:0] cfg_div = '0, cfg_duty = '0;
   logic        cfg_ready, fm, period_tick, active;
   int          tests = 0, fails = 0;

`ifdef FP_DUTY_EN
   localparam int D1 = 3, D2 = 0, D3 = 5, D4 = 9;
`else
   localparam int D1 = 5, D2 = 1, D3 = 2, D4 = 5;
`endif

   fp_prog_div dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_div     (cfg_div),
      .cfg_duty    (cfg_duty),
      .fm          (fm),
      .period_tick (period_tick),
      .active      (active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int k, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
      end
   endtask

   task automatic run_check(input int n, input int div, input int duty, input int start, input logic rdy);
      for (int i = 0; i < n; i++) begin
         int k;
         @(posedge clk);
         #1;
         k = (start + i) % div;
         chk("fm", k, fm, (k < duty) ? 1'b0 : 1'b1);
         chk("period_tick", k, period_tick, k == 0);
         chk("active", k, active, 1'b1);
         chk("cfg_ready", k, cfg_ready, rdy);
      end
   endtask

   task automatic idle_check(input string tag);
      chk({tag, "_fm"}, 0, fm, 1'b1);
      chk({tag, "_tick"}, 0, period_tick, 1'b0);
      chk({tag, "_active"}, 0, active, 1'b0);
      chk({tag, "_ready"}, 0, cfg_ready, 1'b1);
   endtask

   initial begin
      #12;
      idle_check("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      en    = 1'b1;
      // defaults: 25 low / 25 high, ticks every 50, then stop at cnt=12
      run_check(63, 50, 25, 0, 1'b1);
      en = 1'b0;
      @(posedge clk);
      #1;
      idle_check("stop");
      @(posedge clk);
      #1;
      idle_check("idle");
      en = 1'b1;
      run_check(70, 50, 25, 0, 1'b1);
      // handshake div=10 duty=3 mid-period, applied at the next boundary
      cfg_valid = 1'b1;
      cfg_div   = 16'd10;
      cfg_duty  = 16'd3;
      run_check(1, 50, 25, 20, 1'b0);
      cfg_valid = 1'b0;
      run_check(29, 50, 25, 21, 1'b0);
      run_check(20, 10, D1, 0, 1'b1);
      // div=1 clamps to 2, duty=0 keeps fm high
      cfg_valid = 1'b1;
      cfg_div   = 16'd1;
      cfg_duty  = 16'd0;
      run_check(1, 10, D1, 0, 1'b0);
      cfg_valid = 1'b0;
      run_check(9, 10, D1, 1, 1'b0);
      run_check(6, 2, D2, 0, 1'b1);
      // duty >= div keeps fm low
      cfg_valid = 1'b1;
      cfg_div   = 16'd4;
      cfg_duty  = 16'd5;
      run_check(1, 2, D2, 0, 1'b0);
      cfg_valid = 1'b0;
      run_check(1, 2, D2, 1, 1'b0);
      run_check(13, 4, D3, 0, 1'b1);
      // leave a config pending, then reset mid-period
      cfg_valid = 1'b1;
      cfg_div   = 16'd7;
      cfg_duty  = 16'd1;
      run_check(1, 4, D3, 1, 1'b0);
      cfg_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      idle_check("async_rst");
      @(posedge clk);
      #1;
      idle_check("held_rst");
      en    = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle_check("post_rst");
      en = 1'b1;
      run_check(55, 50, 25, 0, 1'b1);
      // div=11 duty=9
      cfg_valid = 1'b1;
      cfg_div   = 16'd11;
      cfg_duty  = 16'd9;
      run_check(1, 50, 25, 5, 1'b0);
      cfg_valid = 1'b0;
      run_check(44, 50, 25, 6, 1'b0);
      run_check(22, 11, D4, 0, 1'b1);
      en = 1'b0;
      @(posedge clk);
      #1;
      idle_check("final");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fp_prog_div.md
Name: fp_prog_div

Overview:
- Runtime-programmable square-wave divider that drives the active-low beeper gate.
- The period (divisor) and the low-phase length (duty) are loaded through a valid/ready config port.
- New settings are applied glitch-free at period boundaries.
- Sits between the control/sequencer logic and the beeper pin, replacing fixed-ratio dividers.

Parameters:
- CNT_W, 16, width of counter, divisor and duty.
- DEF_DIV, 50, divisor after reset (period in clk cycles).
- DEF_DUTY, 25, low-phase cycles after reset.
- IDLE_LVL, 1, fm level when stopped (beeper not active).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  run enable; level-sensitive.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config slot free.
- cfg_div  in  CNT_W  requested period in cycles.
- cfg_duty  in  CNT_W  requested low-phase cycles.
- fm  out  1  beeper gate; low = active.
- period_tick  out  1  one-cycle pulse at each period start.
- active  out  1  high while in RUN.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, fm=IDLE_LVL, period_tick=0, active=0, cfg_ready=1, pending=0, div=DEF_DIV, duty=DEF_DUTY.
- All outputs are registered.
- States:
  - IDLE -> RUN when en=1 at an edge.
  - RUN -> IDLE when en=0 at an edge. This is an abrupt stop, not deferred to the period end.
- On entering RUN: cnt<=0, period_tick<=1, fm<=(duty>0 ? 0 : 1), active<=1.
- In RUN:
  - cnt counts 0..div-1 and wraps to 0.
  - fm<=0 while next cnt<duty, else 1. This is aligned so fm reflects the cnt value held in the same cycle.
  - period_tick=1 exactly in cycles where cnt==0.
- On entering IDLE: cnt<=0, fm<=IDLE_LVL, period_tick<=0, active<=0.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready at an edge.
  - The transfer captures cfg_div/cfg_duty into shadow regs, sets pending=1 and drops cfg_ready.
  - cfg_valid may be held; only the handshake cycle samples.
- Shadow apply:
  - In RUN, applied on the edge where cnt==div-1, so the new period starts at cnt=0.
  - In IDLE, applied on the next edge.
  - On apply, pending=0 and cfg_ready=1 from the following cycle.
  - Only one pending config is held; there is no queue.
- Clamping:
  - A captured divisor below 2 is stored as 2.
  - duty=0 gives fm constantly 1 (silent, still ticking).
  - duty>=div gives fm constantly 0 in RUN.
- Simultaneous events:
  - en falling with an apply in the same cycle: apply still takes effect, state goes to IDLE.
  - Handshake while pending is impossible (cfg_ready=0).
- Reset mid-operation: immediate return to reset values and any pending config is discarded.
- Counter width: cnt uses CNT_W bits with no overflow, since div<=2^CNT_W-1.

Optional Feature:
- Macro FP_DUTY_EN.
- Defined: cfg_duty is captured and used as above (programmable duty).
- Undefined:
  - cfg_duty is ignored, and duty is derived as div>>1 at every apply and at reset (DEF_DUTY ignored). This gives a fixed ~50% wave; for div=50 that is 25 low / 25 high.
  - The port remains present for interface stability.

Decomposition:
- Package fp_pkg:
  - state enum (FP_IDLE, FP_RUN).
  - FP_MIN_DIV=2.
  - default CNT_W constant.
- Sub-module fp_cfg_shadow: holds the shadow regs, pending flag, cfg_ready, clamp and duty derivation; outputs div/duty on an apply strobe from the top-level counter FSM.

Test Plan:
- Reset defaults -> fm=1, cfg_ready=1, active=0.
- en=1 with defaults -> fm low 25 cycles, high 25 cycles, period_tick every 50 cycles, first tick on the first RUN cycle.
- In RUN, handshake div=10, duty=3 at cnt=20 -> current 50-cycle period completes unchanged; next period 3 low / 7 high; cfg_ready low until the apply, then high.
- Handshake div=1, duty=0 -> stored div=2, fm constantly 1, period_tick every 2 cycles. Then duty=5, div=4 -> fm constantly 0 (FP_DUTY_EN defined).
- en dropped at cnt=12 -> next cycle fm=1, active=0, cnt=0. Re-enable -> restarts at cnt=0 with a tick.
- rst_n asserted mid-period with a config pending -> all outputs at reset values asynchronously; after release the divisor is 50 and the pending config is lost. Without FP_DUTY_EN: config div=11, duty=9 -> 5 low / 6 high.
